sseg_scan_ctrl: RTL

Parametrised multiplexed seven-segment display controller: time-division scans `N_DIGITS` common-anode digits, decodes 4-bit hex per digit, and adds per-digit blanking, per-digit blinking, leading-zero suppression and PWM brightness control. It sits between the button-detection/counter logic and the board's `an`/`sseg` pins. It is the drop-in generalisation of the existing 4-digit hex mux for boards with 2–8 digits and for UI features that need dimming and blink.

---
 rtl/sseg_scan_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner with blanking, blink, leading-zero suppression and PWM dimming.
// All outputs are registered (1-cycle latency); there is no flow control.
module sseg_scan_ctrl #(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 65536,
    parameter int BRIGHT_W  = 3,
    parameter int BLINK_DIV = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [N_DIGITS-1:0]     blink_in,
    input  logic                    lzb_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int CW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW  = $clog2(N_DIGITS);
    localparam int BFW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [31:0] STEP = 32'(PRESCALE >> BRIGHT_W);

    logic [CW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [DW-1:0]       digit_idx_q, digit_idx_d;
    logic [BFW-1:0]      blink_frames_q, blink_frames_d;
    logic                blink_phase_q, blink_phase_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [7:0]          sseg_q, sseg_d;
    logic                frame_tick_q, frame_tick_d;

    logic        slot_end, frame_end;
    logic [3:0]  cur_hex;
    logic        cur_dp, cur_dark, cur_zero_run, suppress;
    logic [31:0] on_time;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        slot_end       = (slot_cnt_q == CW'(PRESCALE - 1));
        frame_end      = slot_end && (digit_idx_q == DW'(N_DIGITS - 1));
        slot_cnt_d     = slot_end ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d    = digit_idx_q;
        blink_frames_d = blink_frames_q;
        blink_phase_d  = blink_phase_q;
        bright_d       = (slot_cnt_q == '0) ? brightness : bright_q;
        if (slot_end)
            digit_idx_d = frame_end ? '0 : digit_idx_q + 1'b1;
        if (frame_end) begin
            if (blink_frames_q == BFW'(BLINK_DIV - 1)) begin
                blink_frames_d = '0;
                blink_phase_d  = ~blink_phase_q;
            end else begin
                blink_frames_d = blink_frames_q + 1'b1;
            end
        end

        cur_hex      = '0;
        cur_dp       = 1'b0;
        cur_dark     = 1'b0;
        cur_zero_run = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx_q == DW'(i)) begin
                cur_hex      = hex_in[4*i +: 4];
                cur_dp       = dp_in[i];
                cur_dark     = blank_in[i] | (blink_in[i] & blink_phase_q);
                cur_zero_run = ((hex_in >> (4*i)) == '0);
            end
        end
        // Digit 0 always shows, so a value of zero still reads "0".
        suppress = lzb_en && (digit_idx_q != '0) && cur_zero_run;

        on_time = ({{(32-BRIGHT_W){1'b0}}, bright_q} + 32'd1) * STEP;
        an_d    = '1;
        if (!cur_dark && ({{(32-CW){1'b0}}, slot_cnt_q} < on_time))
            an_d[digit_idx_q] = 1'b0;
        sseg_d       = {~cur_dp, suppress ? 7'b1111111 : decode(cur_hex)};
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q     <= '0;
            digit_idx_q    <= '0;
            blink_frames_q <= '0;
            blink_phase_q  <= 1'b0;
            bright_q       <= '0;
            an_q           <= '1;
            sseg_q         <= 8'hFF;
            frame_tick_q   <= 1'b0;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            digit_idx_q    <= digit_idx_d;
            blink_frames_q <= blink_frames_d;
            blink_phase_q  <= blink_phase_d;
            bright_q       <= bright_d;
            an_q           <= an_d;
            sseg_q         <= sseg_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule
